hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Parametrised data-hazard unit for the 5-stage pipelined core: fetch, decode, execution, memory, writeback.
- Holds its own scoreboard of the instructions in the execution, memory and writeback stages.
- Drives the execution-stage operand forwarding mux selects, load-use stalls/bubbles, and a global freeze when data memory is not ready.
- Replaces the hard-wired zero selects on the execution-stage operand muxes.

Parameters:
REG_AW, 4, register address width
NUM_SRC, 2, source operands per instruction
ZERO_REG_HARD, 0, 1 = register 0 reads as constant, never forwarded nor stalled on

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
dec_valid  in  1  decode holds a live instruction (0 when squashed by the branch unit)
dec_src  in  NUM_SRC*REG_AW  decode source addresses, src i at [i*REG_AW +: REG_AW]
dec_src_used  in  NUM_SRC  bit i = src i actually read
dec_dst  in  REG_AW  decode destination register
dec_regw  in  1  decode instruction writes a register
dec_memtoreg  in  1  decode instruction is a load
mem_ready  in  1  data memory completes this cycle
fwd_sel  out  2*NUM_SRC  per src: 00 register bank, 01 memory-stage ALU result, 10 writeback result
stall_fd  out  1  hold PC and fetch/decode register
bubble_e  out  1  flush decode/execution register
freeze_emw  out  1  hold the execution/memory and memory/writeback registers

Behaviour:
- Slot state: three slots, EX, MEM and WB. Each slot holds valid, dst, regw and memtoreg. The EX slot also holds src and src_used.
- Reset: while rst=0, all slots are invalid. fwd_sel=0, stall_fd=0, bubble_e=0, freeze_emw=0.
- Reset mid-operation clears every slot immediately; no partial state survives.
- Match(slot, i) is true when all of the following hold:
  - slot.valid & slot.regw & EX.src_used[i]
  - EX.src[i]==slot.dst
  - with ZERO_REG_HARD=1, also slot.dst!=0
- fwd_sel[i] (combinational from slot registers):
  - 01 if Match(MEM,i)
  - else 10 if Match(WB,i)
  - else 00
  - MEM has priority: it holds the newest value.
- Write-back to decode needs no hazard handling: the register bank writes on the falling edge.
- Load-use hazard, load_use = EX.valid & EX.regw & EX.memtoreg & dec_valid & (some i with dec_src_used[i] & dec_src[i]==EX.dst, dst!=0 if ZERO_REG_HARD).
- freeze = ~mem_ready. All outputs are combinational from slot state and inputs.
- Priority 1, freeze: freeze_emw=1, stall_fd=1, bubble_e=0. All slots hold. The load-use check is suppressed and re-evaluated on the first ready cycle.
- Priority 2, load_use: stall_fd=1, bubble_e=1, freeze_emw=0.
  - Clock edge: EX becomes invalid (bubble), MEM<=EX, WB<=MEM.
  - The stall lasts exactly 1 cycle. Next cycle the load sits in MEM and the consumer gets fwd_sel=10 from WB after one more advance.
- Priority 3, normal: all outputs 0.
  - Clock edge: EX<=decode fields with valid=dec_valid, MEM<=EX, WB<=MEM.
- dec_valid=0 never causes a stall and loads an invalid EX slot.
- Same dst in MEM and WB: the MEM value is forwarded.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, two extra outputs are present:
  - stall_cycles (32-bit): increments on every cycle with stall_fd=1.
  - load_use_cnt (16-bit): increments on each load_use cycle.
  - Both reset to 0, wrap modulo 2^width, and hold during rst=0.
- When undefined, both ports and counters are absent; all other behaviour is identical.

Test Plan:
- ADD r3 then ADD r5,r3,r1 back-to-back, mem_ready=1 -> in the consumer's EX cycle fwd_sel[1:0]=01, no stall.
- ADD r3, NOP, then SUB r6,r2,r3 -> fwd_sel[3:2]=10 in SUB's EX cycle.
- LOAD r4 then ADD r7,r4,r4 -> one cycle with stall_fd=1 and bubble_e=1. Next cycle: no stall. In the ADD's EX cycle fwd_sel=1010.
- LOAD r4 in EX with mem_ready held 0 for 3 cycles -> freeze_emw=stall_fd=1 for 3 cycles with slots unchanged. Then a single load-use bubble. With HAZARD_PERF_CNT_EN, stall_cycles=4.
- ZERO_REG_HARD=1, ADD r0 then ADD r1,r0,r0 -> fwd_sel=0000. Same sequence with ZERO_REG_HARD=0 -> fwd_sel=0101.
- rst driven to 0 asynchronously mid-stall -> all outputs 0 within the same cycle. After release, the first instruction sees fwd_sel=0.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit: EX-stage operand forwarding, load-use stall and memory freeze (opt. HAZARD_PERF_CNT_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_forward_unit #(
  parameter int REG_AW        = 4,
  parameter int NUM_SRC       = 2,
  parameter int ZERO_REG_HARD = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dec_valid,
  input  logic [NUM_SRC*REG_AW-1:0] dec_src,
  input  logic [NUM_SRC-1:0]        dec_src_used,
  input  logic [REG_AW-1:0]         dec_dst,
  input  logic                      dec_regw,
  input  logic                      dec_memtoreg,
  input  logic                      mem_ready,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall_fd,
  output logic                      bubble_e,
  output logic                      freeze_emw
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [15:0]               load_use_cnt
`endif
);

  localparam logic C_ZERO_CHK = (ZERO_REG_HARD != 0);

  logic                      ex_valid_q, ex_regw_q, ex_memtoreg_q;
  logic [REG_AW-1:0]         ex_dst_q;
  logic [NUM_SRC*REG_AW-1:0] ex_src_q;
  logic [NUM_SRC-1:0]        ex_src_used_q;
  logic                      mem_valid_q, mem_regw_q, mem_memtoreg_q;
  logic [REG_AW-1:0]         mem_dst_q;
  logic                      wb_valid_q, wb_regw_q, wb_memtoreg_q;
  logic [REG_AW-1:0]         wb_dst_q;

  logic               ex_dst_ok, mem_dst_ok, wb_dst_ok;
  logic [NUM_SRC-1:0] lu_hit;
  logic               freeze, load_use;

  assign ex_dst_ok  = !C_ZERO_CHK || (ex_dst_q  != '0);
  assign mem_dst_ok = !C_ZERO_CHK || (mem_dst_q != '0);
  assign wb_dst_ok  = !C_ZERO_CHK || (wb_dst_q  != '0);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] ex_src;
    logic              mem_hit, wb_hit;

    assign ex_src  = ex_src_q[i*REG_AW +: REG_AW];
    assign mem_hit = mem_valid_q & mem_regw_q & ex_src_used_q[i] &
                     (ex_src == mem_dst_q) & mem_dst_ok;
    assign wb_hit  = wb_valid_q & wb_regw_q & ex_src_used_q[i] &
                     (ex_src == wb_dst_q) & wb_dst_ok;
    // MEM holds the younger producer, so it wins over WB
    assign fwd_sel[2*i +: 2] = mem_hit ? 2'b01 : (wb_hit ? 2'b10 : 2'b00);
    assign lu_hit[i] = dec_src_used[i] & (dec_src[i*REG_AW +: REG_AW] == ex_dst_q);
  end

  // Gated by rst so a pending freeze cannot leak out while in reset
  assign freeze     = rst & ~mem_ready;
  assign load_use   = ~freeze & ex_valid_q & ex_regw_q & ex_memtoreg_q &
                      dec_valid & (|lu_hit) & ex_dst_ok;
  assign stall_fd   = freeze | load_use;
  assign bubble_e   = load_use;
  assign freeze_emw = freeze;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q     <= 1'b0;
      ex_regw_q      <= 1'b0;
      ex_memtoreg_q  <= 1'b0;
      ex_dst_q       <= '0;
      ex_src_q       <= '0;
      ex_src_used_q  <= '0;
      mem_valid_q    <= 1'b0;
      mem_regw_q     <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_dst_q      <= '0;
      wb_valid_q     <= 1'b0;
      wb_regw_q      <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      wb_dst_q       <= '0;
    end else if (!freeze) begin
      wb_valid_q     <= mem_valid_q;
      wb_regw_q      <= mem_regw_q;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_dst_q       <= mem_dst_q;
      mem_valid_q    <= ex_valid_q;
      mem_regw_q     <= ex_regw_q;
      mem_memtoreg_q <= ex_memtoreg_q;
      mem_dst_q      <= ex_dst_q;
      if (load_use) begin
        ex_valid_q <= 1'b0;
      end else begin
        ex_valid_q    <= dec_valid;
        ex_regw_q     <= dec_regw;
        ex_memtoreg_q <= dec_memtoreg;
        ex_dst_q      <= dec_dst;
        ex_src_q      <= dec_src;
        ex_src_used_q <= dec_src_used;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] load_use_cnt_q, load_use_cnt_d;

  assign stall_cycles_d = stall_fd ? stall_cycles_q + 32'd1 : stall_cycles_q;
  assign load_use_cnt_d = load_use ? load_use_cnt_q + 16'd1 : load_use_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      load_use_cnt_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      load_use_cnt_q <= load_use_cnt_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign load_use_cnt = load_use_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_unit: table-driven bench for hazard_forward_unit, ZERO_REG_HARD=0 and =1 side by side
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid;
  logic [7:0] dec_src;
  logic [1:0] dec_src_used;
  logic [3:0] dec_dst;
  logic       dec_regw, dec_memtoreg, mem_ready;
  logic [3:0] fwd_sel, fwd_sel_z;
  logic       stall_fd, bubble_e, freeze_emw;
  logic       stall_fd_z, bubble_e_z, freeze_emw_z;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, stall_cycles_z;
  logic [15:0] load_use_cnt, load_use_cnt_z;
`endif

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_AW(4), .NUM_SRC(2), .ZERO_REG_HARD(0)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src(dec_src),
    .dec_src_used(dec_src_used), .dec_dst(dec_dst), .dec_regw(dec_regw),
    .dec_memtoreg(dec_memtoreg), .mem_ready(mem_ready), .fwd_sel(fwd_sel),
    .stall_fd(stall_fd), .bubble_e(bubble_e), .freeze_emw(freeze_emw)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .load_use_cnt(load_use_cnt)
`endif
  );

  hazard_forward_unit #(.REG_AW(4), .NUM_SRC(2), .ZERO_REG_HARD(1)) dut_z (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src(dec_src),
    .dec_src_used(dec_src_used), .dec_dst(dec_dst), .dec_regw(dec_regw),
    .dec_memtoreg(dec_memtoreg), .mem_ready(mem_ready), .fwd_sel(fwd_sel_z),
    .stall_fd(stall_fd_z), .bubble_e(bubble_e_z), .freeze_emw(freeze_emw_z)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles_z), .load_use_cnt(load_use_cnt_z)
`endif
  );

  typedef struct {
    logic       v;
    logic [3:0] s1, s0;
    logic [1:0] used;
    logic [3:0] dst;
    logic       regw, mtr, rdy;
    logic [3:0] fwd, fwdz;
    logic       fcare, st, bu, fr;
  } vec_t;

  vec_t tbl[$];
  vec_t t;
  int   errors = 0;
  int   checks = 0;
  int   exp_stalls = 0;
  int   exp_lu = 0;

  function automatic vec_t op(logic v, logic [3:0] s1, logic [3:0] s0, logic [1:0] used,
                              logic [3:0] dst, logic mtr, logic rdy, logic [3:0] fwd,
                              logic st, logic bu, logic fr);
    vec_t r;
    r.v = v; r.s1 = s1; r.s0 = s0; r.used = used; r.dst = dst; r.regw = 1'b1;
    r.mtr = mtr; r.rdy = rdy; r.fwd = fwd; r.fwdz = fwd; r.fcare = 1'b1;
    r.st = st; r.bu = bu; r.fr = fr;
    return r;
  endfunction

  function automatic vec_t nop(logic [3:0] fwd, logic [3:0] fwdz, logic fcare);
    vec_t r;
    r = op(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b1, fwd, 1'b0, 1'b0, 1'b0);
    r.regw = 1'b0; r.fwdz = fwdz; r.fcare = fcare;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t x);
    dec_valid    = x.v;
    dec_src      = {x.s1, x.s0};
    dec_src_used = x.used;
    dec_dst      = x.dst;
    dec_regw     = x.regw;
    dec_memtoreg = x.mtr;
    mem_ready    = x.rdy;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, " fwd_sel"}, {28'd0, fwd_sel}, 32'd0);
    check({tag, " stall_fd"}, {31'd0, stall_fd}, 32'd0);
    check({tag, " bubble_e"}, {31'd0, bubble_e}, 32'd0);
    check({tag, " freeze_emw"}, {31'd0, freeze_emw}, 32'd0);
    check({tag, " z fwd/stall"}, {27'd0, fwd_sel_z, stall_fd_z}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check({tag, " stall_cycles"}, stall_cycles, 32'd0);
    check({tag, " load_use_cnt"}, {16'd0, load_use_cnt}, 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // ADD r3 -> ADD r5,r3,r1 (MEM forward on src0)
    tbl.push_back(op(1, 4'd2, 4'd1, 2'b11, 4'd3, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(op(1, 4'd1, 4'd3, 2'b11, 4'd5, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(nop(4'b0001, 4'b0001, 1));
    tbl.push_back(nop(4'b0000, 4'b0000, 1));
    tbl.push_back(nop(4'b0000, 4'b0000, 1));
    // ADD r3, NOP, SUB r6,r2,r3 (WB forward on src1)
    tbl.push_back(op(1, 4'd2, 4'd1, 2'b11, 4'd3, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(nop(4'b0000, 4'b0000, 1));
    tbl.push_back(op(1, 4'd3, 4'd2, 2'b11, 4'd6, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(nop(4'b1000, 4'b1000, 1));
    tbl.push_back(nop(4'b0000, 4'b0000, 1));
    tbl.push_back(nop(4'b0000, 4'b0000, 1));
    // ADD r3, ADD r3, ADD r8,r3,r3 (MEM wins over WB)
    tbl.push_back(op(1, 4'd2, 4'd1, 2'b11, 4'd3, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(op(1, 4'd2, 4'd1, 2'b11, 4'd3, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(op(1, 4'd3, 4'd3, 2'b11, 4'd8, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(nop(4'b0101, 4'b0101, 1));
    tbl.push_back(nop(4'b0000, 4'b0000, 1));
    tbl.push_back(nop(4'b0000, 4'b0000, 1));
    // LOAD r4 -> ADD r7,r4,r4 (one bubble, then WB forward)
    tbl.push_back(op(1, 4'd0, 4'd1, 2'b01, 4'd4, 1, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(op(1, 4'd4, 4'd4, 2'b11, 4'd7, 0, 1, 4'b0000, 1, 1, 0));
    tbl.push_back(op(1, 4'd4, 4'd4, 2'b11, 4'd7, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(nop(4'b1010, 4'b1010, 1));
    tbl.push_back(nop(4'b0000, 4'b0000, 1));
    tbl.push_back(nop(4'b0000, 4'b0000, 1));
    // Same pair with mem_ready low for 3 cycles: freeze first, then bubble
    tbl.push_back(op(1, 4'd0, 4'd1, 2'b01, 4'd4, 1, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(op(1, 4'd4, 4'd4, 2'b11, 4'd7, 0, 0, 4'b0000, 1, 0, 1));
    tbl.push_back(op(1, 4'd4, 4'd4, 2'b11, 4'd7, 0, 0, 4'b0000, 1, 0, 1));
    tbl.push_back(op(1, 4'd4, 4'd4, 2'b11, 4'd7, 0, 0, 4'b0000, 1, 0, 1));
    tbl.push_back(op(1, 4'd4, 4'd4, 2'b11, 4'd7, 0, 1, 4'b0000, 1, 1, 0));
    tbl.push_back(op(1, 4'd4, 4'd4, 2'b11, 4'd7, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(nop(4'b1010, 4'b1010, 1));
    tbl.push_back(nop(4'b0000, 4'b0000, 1));
    tbl.push_back(nop(4'b0000, 4'b0000, 1));
    // ADD r0 -> ADD r1,r0,r0 (r0 forwarded only when not hard-wired)
    tbl.push_back(op(1, 4'd3, 4'd2, 2'b11, 4'd0, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(op(1, 4'd0, 4'd0, 2'b11, 4'd1, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(nop(4'b0101, 4'b0000, 1));
    tbl.push_back(nop(4'b0000, 4'b0000, 1));
    tbl.push_back(nop(4'b0000, 4'b0000, 1));
    // LOAD r4 followed by a squashed reader of r4: no stall
    tbl.push_back(op(1, 4'd0, 4'd1, 2'b01, 4'd4, 1, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(op(0, 4'd4, 4'd4, 2'b11, 4'd7, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(nop(4'b0000, 4'b0000, 0));
    tbl.push_back(nop(4'b0000, 4'b0000, 1));

    // Reset state, with inputs that would otherwise freeze
    rst = 1'b0;
    drive(op(1, 4'd4, 4'd4, 2'b11, 4'd7, 1, 0, 4'b0000, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    drive(nop(4'b0000, 4'b0000, 1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < tbl.size(); k++) begin
      t = tbl[k];
      drive(t);
      #4;
      if (t.fcare) begin
        check($sformatf("vec%0d fwd_sel", k), {28'd0, fwd_sel}, {28'd0, t.fwd});
        check($sformatf("vec%0d fwd_sel_z", k), {28'd0, fwd_sel_z}, {28'd0, t.fwdz});
      end
      check($sformatf("vec%0d stall/bubble/freeze", k),
            {29'd0, stall_fd, bubble_e, freeze_emw}, {29'd0, t.st, t.bu, t.fr});
      check($sformatf("vec%0d z stall/bubble/freeze", k),
            {29'd0, stall_fd_z, bubble_e_z, freeze_emw_z}, {29'd0, t.st, t.bu, t.fr});
      if (t.st) exp_stalls++;
      if (t.bu) exp_lu++;
      @(posedge clk);
      #1;
    end

`ifdef HAZARD_PERF_CNT_EN
    check("stall_cycles total", stall_cycles, exp_stalls);
    check("load_use_cnt total", {16'd0, load_use_cnt}, exp_lu);
    check("z stall_cycles total", stall_cycles_z, exp_stalls);
`endif

    // Asynchronous reset in the middle of a frozen load-use stall
    drive(op(1, 4'd0, 4'd1, 2'b01, 4'd4, 1, 1, 4'b0000, 0, 0, 0));
    @(posedge clk);
    #1;
    drive(op(1, 4'd4, 4'd4, 2'b11, 4'd7, 0, 0, 4'b0000, 0, 0, 0));
    #2;
    check("pre-reset stall_fd", {31'd0, stall_fd}, 32'd1);
    rst = 1'b0;
    #1;
    check_all_zero("mid-stall reset");
    drive(op(1, 4'd4, 4'd4, 2'b11, 4'd7, 0, 1, 4'b0000, 0, 0, 0));
    #1;
    rst = 1'b1;
    #1;
    check("post-reset stall_fd", {31'd0, stall_fd}, 32'd0);
    check("post-reset bubble_e", {31'd0, bubble_e}, 32'd0);
    @(posedge clk);
    #1;
    drive(nop(4'b0000, 4'b0000, 1));
    #1;
    check("post-reset first fwd_sel", {28'd0, fwd_sel}, 32'd0);
    check("post-reset first fwd_sel_z", {28'd0, fwd_sel_z}, 32'd0);
    check("post-reset stall", {31'd0, stall_fd}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
